mult_prec_scalable_mac_pipelined: RTL and testbench

Pipelined, precision-scalable multiply-accumulate unit. It is the successor to the combinational 16x16 / 2x8x8 / 4x4x4 fracturable multiplier.
- Width is parametrised.
- Precision mode is carried per beat through a valid-qualified pipeline.
- Each lane has its own accumulator with guard bits and a sticky overflow flag.
- Intended as the arithmetic core of the next PIR-DSP-style block.

---
 rtl/mult_prec_pkg.sv | 41 ++++
 rtl/mult_prec_scalable_core.sv | 45 ++++
 rtl/mult_prec_scalable_mac_pipelined.sv | 158 +++++++++++++++
 tb/tb_mult_prec_scalable_mac_pipelined.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_prec_pkg.sv
// Shared mode encodings and lane-geometry helpers for the precision-scalable MAC.
package mult_prec_pkg;

   typedef enum logic [1:0] {
      MODE_FULL    = 2'b00,
      MODE_HALF    = 2'b01,
      MODE_QUARTER = 2'b10
   } mode_e;

   localparam int MAX_LANES = 4;

   // Encoding 11 is folded onto full mode so later comparisons see one canonical value.
   function automatic mode_e norm_mode(input logic [1:0] m);
      case (m)
         2'b01:   return MODE_HALF;
         2'b10:   return MODE_QUARTER;
         default: return MODE_FULL;
      endcase
   endfunction

   function automatic mode_e mode_at(input int idx);
      case (idx)
         1:       return MODE_HALF;
         2:       return MODE_QUARTER;
         default: return MODE_FULL;
      endcase
   endfunction

   function automatic int lane_count(input mode_e m);
      case (m)
         MODE_HALF:    return 2;
         MODE_QUARTER: return 4;
         default:      return 1;
      endcase
   endfunction

   function automatic int slice_w(input int total, input mode_e m);
      return total / lane_count(m);
   endfunction

endpackage

// File: rtl/mult_prec_scalable_core.sv
// Combinational fracturable multiplier: one WxW, two (W/2)x(W/2) or four (W/4)x(W/4)
// products, each sign-extended into its CW/L slice of the packed result.
module mult_prec_scalable_core
   import mult_prec_pkg::*;
#(
   parameter  int W  = 16,
   parameter  int G  = 4,
   localparam int CW = 2*W + 4*G
) (
   input  logic [W-1:0]  a,
   input  logic [W-1:0]  b,
   input  logic          a_sign,
   input  logic          b_sign,
   input  mode_e         mode,
   output logic [CW-1:0] prod
);

   logic [2:0][CW-1:0] prod_m;

   for (genvar m = 0; m < 3; m++) begin : g_mode
      localparam int L  = lane_count(mode_at(m));
      localparam int LW = W / L;
      localparam int SW = slice_w(CW, mode_at(m));

      for (genvar k = 0; k < L; k++) begin : g_lane
         logic signed [SW-1:0] a_ext;
         logic signed [SW-1:0] b_ext;

         // Extending both operands to the slice width makes the modular product
         // the already sign-extended lane result, covering the mixed-sign case too.
         assign a_ext = {{(SW-LW){a_sign & a[k*LW+LW-1]}}, a[k*LW +: LW]};
         assign b_ext = {{(SW-LW){b_sign & b[k*LW+LW-1]}}, b[k*LW +: LW]};
         assign prod_m[m][k*SW +: SW] = a_ext * b_ext;
      end
   end

   always_comb begin
      case (mode)
         MODE_HALF:    prod = prod_m[1];
         MODE_QUARTER: prod = prod_m[2];
         default:      prod = prod_m[0];
      endcase
   end

endmodule

// File: rtl/mult_prec_scalable_mac_pipelined.sv
// Three-stage precision-scalable MAC: input register, lane products, per-lane
// accumulators with guard bits and sticky overflow.
module mult_prec_scalable_mac_pipelined
   import mult_prec_pkg::*;
#(
   parameter  int W  = 16,
   parameter  int G  = 4,
   localparam int CW = 2*W + 4*G
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   input  logic          A_sign,
   input  logic          B_sign,
   input  logic [1:0]    MODE,
   input  logic          acc_en,
   output logic          out_valid,
   output logic [CW-1:0] C,
   output logic [3:0]    ovf
);

   function automatic logic lane_ovf(input logic sgn, input logic carry,
                                     input logic acc_msb, input logic add_msb,
                                     input logic sum_msb);
      if (sgn) return (acc_msb == add_msb) && (sum_msb != acc_msb);
      return carry;
   endfunction

   logic          vld_p0;
   logic [W-1:0]  a_p0;
   logic [W-1:0]  b_p0;
   logic          as_p0;
   logic          bs_p0;
   mode_e         mode_p0;
   logic          acc_en_p0;

   logic [CW-1:0] prod;

   logic          vld_p1;
   logic [CW-1:0] prod_p1;
   mode_e         mode_p1;
   logic          sgn_p1;
   logic          acc_en_p1;

   mode_e         mode_q;
   logic          sgn_q;
   logic          load;

   logic [2:0][CW-1:0] acc_m;
   logic [2:0][3:0]    ovf_m;
   logic [CW-1:0]      c_nxt;
   logic [3:0]         ovf_nxt;

   // ---- S1: input register ----
   always_ff @(posedge clk) begin
      if (reset) vld_p0 <= 1'b0;
      else       vld_p0 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (in_valid) begin
         a_p0      <= A;
         b_p0      <= B;
         as_p0     <= A_sign;
         bs_p0     <= B_sign;
         mode_p0   <= norm_mode(MODE);
         acc_en_p0 <= acc_en;
      end
   end

   mult_prec_scalable_core #(
      .W (W),
      .G (G)
   ) u_core (
      .a      (a_p0),
      .b      (b_p0),
      .a_sign (as_p0),
      .b_sign (bs_p0),
      .mode   (mode_p0),
      .prod   (prod)
   );

   // ---- S2: lane product register ----
   always_ff @(posedge clk) begin
      if (reset) vld_p1 <= 1'b0;
      else       vld_p1 <= vld_p0;
   end

   always_ff @(posedge clk) begin
      if (vld_p0) begin
         prod_p1   <= prod;
         mode_p1   <= mode_p0;
         sgn_p1    <= as_p0 | bs_p0;
         acc_en_p1 <= acc_en_p0;
      end
   end

   // ---- S3: per-lane accumulate ----
   // A change of lane geometry or signedness makes the old sums meaningless, so it restarts them.
   assign load = !acc_en_p1 || (mode_p1 != mode_q) || (sgn_p1 != sgn_q);

   for (genvar m = 0; m < 3; m++) begin : g_acc
      localparam int L  = lane_count(mode_at(m));
      localparam int SW = slice_w(CW, mode_at(m));

      for (genvar k = 0; k < L; k++) begin : g_lane
         logic [SW:0] sum;

         assign sum = {1'b0, C[k*SW +: SW]} + {1'b0, prod_p1[k*SW +: SW]};
         assign acc_m[m][k*SW +: SW] = load ? prod_p1[k*SW +: SW] : sum[SW-1:0];
         assign ovf_m[m][k] = !load &&
                              (ovf[k] || lane_ovf(sgn_p1, sum[SW], C[k*SW+SW-1],
                                                  prod_p1[k*SW+SW-1], sum[SW-1]));
      end

      if (L < MAX_LANES) begin : g_unused
         assign ovf_m[m][MAX_LANES-1:L] = '0;
      end
   end

   always_comb begin
      case (mode_p1)
         MODE_HALF: begin
            c_nxt   = acc_m[1];
            ovf_nxt = ovf_m[1];
         end
         MODE_QUARTER: begin
            c_nxt   = acc_m[2];
            ovf_nxt = ovf_m[2];
         end
         default: begin
            c_nxt   = acc_m[0];
            ovf_nxt = ovf_m[0];
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         C         <= '0;
         ovf       <= '0;
         mode_q    <= MODE_FULL;
         sgn_q     <= 1'b0;
      end else begin
         out_valid <= vld_p1;
         if (vld_p1) begin
            C      <= c_nxt;
            ovf    <= ovf_nxt;
            mode_q <= mode_p1;
            sgn_q  <= sgn_p1;
         end
      end
   end

endmodule

// File: tb/tb_mult_prec_scalable_mac_pipelined.sv
// Directed bench for the precision-scalable MAC with an arithmetic reference model.
module tb_mult_prec_scalable_mac_pipelined;

   localparam int W  = 16;
   localparam int G  = 4;
   localparam int CW = 2*W + 4*G;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic [W-1:0]  A = '0;
   logic [W-1:0]  B = '0;
   logic          A_sign = 1'b0;
   logic          B_sign = 1'b0;
   logic [1:0]    MODE = 2'b00;
   logic          acc_en = 1'b0;
   logic          out_valid;
   logic [CW-1:0] C;
   logic [3:0]    ovf;

   always #5 clk = ~clk;

   mult_prec_scalable_mac_pipelined #(.W(W), .G(G)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .A         (A),
      .B         (B),
      .A_sign    (A_sign),
      .B_sign    (B_sign),
      .MODE      (MODE),
      .acc_en    (acc_en),
      .out_valid (out_valid),
      .C         (C),
      .ovf       (ovf)
   );

   typedef struct {
      int          tgt;
      logic [47:0] c;
      logic [3:0]  o;
      bit          has_lit;
      logic [47:0] lc;
      logic [3:0]  lo;
   } exp_t;

   exp_t        q[$];
   int          edges = 0;
   int          n_vec = 0;
   int          n_bad = 0;
   bit          chk_en = 1'b0;
   logic [47:0] held_c = '0;
   logic [3:0]  held_o = '0;

   logic [47:0] m_c = '0;
   logic [3:0]  m_o = '0;
   logic [1:0]  m_mode = 2'b00;
   bit          m_sgn = 1'b0;

   always @(posedge clk) edges <= edges + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at edge %0d: got %h, expected %h", name, edges, act, exp);
      end
   endtask

   // Reference: lane values interpreted as integers, exact products and sums,
   // wrap and overflow decided from the true mathematical result.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic as,
                        input logic bs, input logic [1:0] md, input logic ae);
      int L, LW, SW;
      logic [1:0] nm;
      bit sgn, load;
      longint av, bv, pv, acc, sum, half, full, newc;
      nm   = (md == 2'b11) ? 2'b00 : md;
      L    = (nm == 2'b00) ? 1 : (nm == 2'b01) ? 2 : 4;
      LW   = 16 / L;
      SW   = 48 / L;
      sgn  = as | bs;
      load = !ae || (nm != m_mode) || (sgn != m_sgn);
      half = 64'sd1 <<< (SW-1);
      full = 64'sd1 <<< SW;
      if (load) m_o = '0;
      newc = 0;
      for (int k = 0; k < L; k++) begin
         av = (longint'(a) >>> (k*LW)) & ((64'sd1 <<< LW) - 1);
         bv = (longint'(b) >>> (k*LW)) & ((64'sd1 <<< LW) - 1);
         if (as && av >= (64'sd1 <<< (LW-1))) av = av - (64'sd1 <<< LW);
         if (bs && bv >= (64'sd1 <<< (LW-1))) bv = bv - (64'sd1 <<< LW);
         pv  = av * bv;
         acc = (longint'(m_c) >>> (k*SW)) & (full - 1);
         if (load) begin
            sum = pv;
         end else if (sgn) begin
            if (acc >= half) acc = acc - full;
            sum = acc + pv;
            if (sum >= half || sum < -half) m_o[k] = 1'b1;
         end else begin
            sum = acc + pv;
            if (sum >= full) m_o[k] = 1'b1;
         end
         newc = newc | ((sum & (full - 1)) <<< (k*SW));
      end
      m_c    = 48'(newc);
      m_mode = nm;
      m_sgn  = sgn;
   endtask

   task automatic beat(input logic [15:0] a, input logic [15:0] b, input logic as,
                       input logic bs, input logic [1:0] md, input logic ae,
                       input bit hl = 1'b0, input logic [47:0] lc = '0,
                       input logic [3:0] lo = '0);
      exp_t e;
      @(posedge clk); #2;
      reset    = 1'b0;
      in_valid = 1'b1;
      A        = a;
      B        = b;
      A_sign   = as;
      B_sign   = bs;
      MODE     = md;
      acc_en   = ae;
      model(a, b, as, bs, md, ae);
      e.tgt     = edges + 3;
      e.c       = m_c;
      e.o       = m_o;
      e.has_lit = hl;
      e.lc      = lc;
      e.lo      = lo;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #2;
         reset    = 1'b0;
         in_valid = 1'b0;
         A        = 16'($urandom);
         B        = 16'($urandom);
         MODE     = 2'($urandom);
         acc_en   = 1'($urandom);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #2;
      reset    = 1'b1;
      in_valid = 1'b0;
      q.delete();
      m_c    = '0;
      m_o    = '0;
      m_mode = 2'b00;
      m_sgn  = 1'b0;
      held_c = '0;
      held_o = '0;
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (chk_en) begin
         if (q.size() > 0 && q[0].tgt == edges) begin
            e = q.pop_front();
            check("out_valid", {63'd0, out_valid}, 64'd1);
            held_c = e.c;
            held_o = e.o;
            if (e.has_lit) begin
               check("lit_C", {16'd0, C}, {16'd0, e.lc});
               check("lit_ovf", {60'd0, ovf}, {60'd0, e.lo});
               check("model_vs_lit", {16'd0, e.c}, {16'd0, e.lc});
            end
         end else begin
            check("out_valid_idle", {63'd0, out_valid}, 64'd0);
         end
         check("C", {16'd0, C}, {16'd0, held_c});
         check("ovf", {60'd0, ovf}, {60'd0, held_o});
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      do_reset();
      chk_en = 1'b1;
      idle(3);

      // full unsigned
      beat(16'hFFFF, 16'hFFFF, 0, 0, 2'b00, 0, 1, 48'h0000FFFE0001, 4'h0);
      idle(3);
      // full signed accumulate
      beat(16'hFFFE, 16'h0003, 1, 1, 2'b00, 0, 1, 48'hFFFFFFFFFFFA, 4'h0);
      beat(16'h0005, 16'h0007, 1, 1, 2'b00, 1, 1, 48'h00000000001D, 4'h0);
      idle(3);
      // mixed signed x unsigned
      beat(16'hFFFF, 16'hFFFF, 1, 0, 2'b00, 0, 1, 48'hFFFFFFFF0001, 4'h0);
      idle(2);
      // half signed
      beat(16'h807F, 16'h80FF, 1, 1, 2'b01, 0, 1, {24'h004000, 24'hFFFF81}, 4'h0);
      idle(3);
      // quarter unsigned accumulate into overflow
      for (int i = 1; i <= 19; i++) begin
         if (i == 17)
            beat(16'hFFFF, 16'hFFFF, 0, 0, 2'b10, 1, 1, {4{12'hEF1}}, 4'h0);
         else if (i == 19)
            beat(16'hFFFF, 16'hFFFF, 0, 0, 2'b10, 1, 1, {4{12'h0B3}}, 4'hF);
         else
            beat(16'hFFFF, 16'hFFFF, 0, 0, 2'b10, logic'(i != 1));
      end
      idle(3);
      // quarter signed overflow: 32 x (-8 * -8) = 2048 exceeds +2047
      for (int i = 1; i <= 33; i++) begin
         if (i == 32)
            beat(16'h8888, 16'h8888, 1, 1, 2'b10, 1, 1, {4{12'h800}}, 4'hF);
         else
            beat(16'h8888, 16'h8888, 1, 1, 2'b10, logic'(i != 1));
      end
      idle(3);
      // mode change acts as a load
      beat(16'h0002, 16'h0002, 0, 0, 2'b00, 0);
      beat(16'h0002, 16'h0002, 0, 0, 2'b00, 1);
      beat(16'h0002, 16'h0002, 0, 0, 2'b00, 1, 1, 48'h00000000000C, 4'h0);
      beat(16'h0303, 16'h0303, 0, 0, 2'b01, 1, 1, {24'd9, 24'd9}, 4'h0);
      // MODE=11 behaves as full: load from half, then accumulate with MODE=00
      beat(16'h0002, 16'h0002, 0, 0, 2'b11, 1, 1, 48'd4, 4'h0);
      beat(16'h0001, 16'h0001, 0, 0, 2'b00, 1, 1, 48'd5, 4'h0);
      idle(3);
      // bubble between beats
      beat(16'h0001, 16'h0001, 0, 0, 2'b00, 0, 1, 48'd1, 4'h0);
      idle(1);
      beat(16'h0002, 16'h0003, 0, 0, 2'b00, 1, 1, 48'd7, 4'h0);
      idle(3);
      // reset mid-stream discards in-flight beats
      beat(16'h1234, 16'h5678, 0, 0, 2'b00, 0);
      beat(16'h0F0F, 16'hF0F0, 1, 1, 2'b01, 0);
      do_reset();
      idle(5);
      // post-reset beat
      beat(16'h0003, 16'h0004, 0, 0, 2'b00, 1, 1, 48'd12, 4'h0);
      idle(4);

      check("drain", 64'(q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
